// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin, line-locked sharing of one byte-wide
// stb/ack serial transmitter between N_INPUTS byte producers.
// A granted producer keeps the transmitter until it sends EOL_CHAR, reaches
// MAX_LINE bytes, or stays idle for TIMEOUT cycles.
// Optional build macro SERIAL_TX_ARBITER_TAG_EN: every grant first emits an
// ASCII source tag ('0' + producer index) ahead of the producer's bytes.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no owner; pick next requester after the last one served
// S_CAPTURE | owner held; take its next byte or count idle cycles
// S_SEND    | byte presented on out1; wait for out1_ack
// S_TAG     | (tag build only) source tag presented; wait for out1_ack
module serial_tx_arbiter #(
   parameter int         N_INPUTS = 4,
   parameter logic [7:0] EOL_CHAR = 8'h0A,
   parameter int         MAX_LINE = 256,
   parameter int         TIMEOUT  = 50000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [8*N_INPUTS-1:0]   in_data,
   input  logic [N_INPUTS-1:0]     in_stb,
   output logic [N_INPUTS-1:0]     in_ack,
   output logic [7:0]              out1,
   output logic                    out1_stb,
   input  logic                    out1_ack,
   output logic [N_INPUTS-1:0]     grant,
   output logic                    busy
);

   localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam int BC_W  = $clog2(MAX_LINE + 1);
   localparam int TO_W  = $clog2(TIMEOUT);

`ifdef SERIAL_TX_ARBITER_TAG_EN
   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_SEND, S_TAG} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_SEND} state_t;
`endif

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     last_q, last_d;
   logic [IDX_W-1:0]     gidx_q, gidx_d;
   logic [N_INPUTS-1:0]  grant_q, grant_d;
   logic [N_INPUTS-1:0]  ack_q, ack_d;
   logic [7:0]           out1_q, out1_d;
   logic                 stb_q, stb_d;
   logic [BC_W-1:0]      bcnt_q, bcnt_d;
   logic [TO_W-1:0]      icnt_q, icnt_d;

   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_ok;
   logic [7:0]           sel_data;
   logic                 sel_stb;

   // Round-robin search: walk from last+N down to last+1 so the closest
   // requester after the last owner is the one that sticks.
   always_comb begin : rr_search
      int cand;
      cand     = 0;
      pick_idx = last_q;
      pick_ok  = 1'b0;
      for (int k = N_INPUTS; k >= 1; k--) begin
         cand = int'(last_q) + k;
         if (cand >= N_INPUTS) cand = cand - N_INPUTS;
         if (in_stb[IDX_W'(cand)]) begin
            pick_idx = IDX_W'(cand);
            pick_ok  = 1'b1;
         end
      end
   end

   // Mux the owner's strobe and byte.
   always_comb begin
      sel_data = 8'h00;
      sel_stb  = 1'b0;
      for (int i = 0; i < N_INPUTS; i++) begin
         if (gidx_q == IDX_W'(i)) begin
            sel_data = in_data[8*i +: 8];
            sel_stb  = in_stb[i];
         end
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gidx_d  = gidx_q;
      grant_d = grant_q;
      ack_d   = '0;
      out1_d  = out1_q;
      stb_d   = stb_q;
      bcnt_d  = bcnt_q;
      icnt_d  = icnt_q;
      case (state_q)
         S_IDLE: begin
            if (pick_ok) begin
               gidx_d           = pick_idx;
               grant_d          = '0;
               grant_d[pick_idx] = 1'b1;
               bcnt_d           = '0;
               icnt_d           = '0;
`ifdef SERIAL_TX_ARBITER_TAG_EN
               out1_d           = 8'h30 + 8'(pick_idx);
               stb_d            = 1'b1;
               state_d          = S_TAG;
`else
               state_d          = S_CAPTURE;
`endif
            end
         end
         S_CAPTURE: begin
            if (sel_stb) begin
               out1_d  = sel_data;
               stb_d   = 1'b1;
               ack_d   = grant_q;
               bcnt_d  = bcnt_q + 1'b1;
               icnt_d  = '0;
               state_d = S_SEND;
            end else if (icnt_q == TO_W'(TIMEOUT - 2)) begin
               // this idle cycle brings the count to TIMEOUT-1: give up the line
               grant_d = '0;
               last_d  = gidx_q;
               state_d = S_IDLE;
            end else begin
               icnt_d = icnt_q + 1'b1;
            end
         end
         S_SEND: begin
            if (out1_ack) begin
               stb_d = 1'b0;
               if ((out1_q == EOL_CHAR) || (bcnt_q == BC_W'(MAX_LINE))) begin
                  grant_d = '0;
                  last_d  = gidx_q;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_CAPTURE;
               end
            end
         end
`ifdef SERIAL_TX_ARBITER_TAG_EN
         S_TAG: begin
            if (out1_ack) begin
               stb_d   = 1'b0;
               state_d = S_CAPTURE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; input 0 wins the first arbitration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         last_q  <= IDX_W'(N_INPUTS - 1);
         gidx_q  <= '0;
         grant_q <= '0;
         ack_q   <= '0;
         out1_q  <= 8'h00;
         stb_q   <= 1'b0;
         bcnt_q  <= '0;
         icnt_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gidx_q  <= gidx_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         out1_q  <= out1_d;
         stb_q   <= stb_d;
         bcnt_q  <= bcnt_d;
         icnt_q  <= icnt_d;
      end
   end

   assign in_ack   = ack_q;
   assign out1     = out1_q;
   assign out1_stb = stb_q;
   assign grant    = grant_q;
   assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter with N_INPUTS=4, MAX_LINE=4, TIMEOUT=10.
// Producers are byte queues; the reference model replays the queues as
// whole lines handed out round-robin.
module tb_serial_tx_arbiter;

   localparam int         N    = 4;
   localparam int         MAXL = 4;
   localparam int         TMO  = 10;
   localparam logic [7:0] EOL  = 8'h0A;
`ifdef SERIAL_TX_ARBITER_TAG_EN
   localparam int         FIRST_STB = 2;
   localparam logic [7:0] BP_BYTE   = 8'h32;
`else
   localparam int         FIRST_STB = 3;
   localparam logic [7:0] BP_BYTE   = 8'h5A;
`endif

   logic         clk;
   logic         rst_n;
   logic [31:0]  in_data;
   logic [3:0]   in_stb;
   logic [3:0]   in_ack;
   logic [7:0]   out1;
   logic         out1_stb;
   logic         out1_ack;
   logic [3:0]   grant;
   logic         busy;

   logic [7:0]   q[4][$];
   logic [7:0]   mq[4][$];
   int           exp_o[$];
   logic [7:0]   exp_b[$];
   logic [3:0]   obs_g[$];
   logic [7:0]   obs_b[$];
   int           ack_cnt[4];
   int           ack_viol;
   int           model_last;
   int           ack_mode;
   int           total;
   int           bad;

   serial_tx_arbiter #(.N_INPUTS(N), .EOL_CHAR(EOL), .MAX_LINE(MAXL), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_stb(in_stb), .in_ack(in_ack),
      .out1(out1), .out1_stb(out1_stb), .out1_ack(out1_ack), .grant(grant), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // producers and transmitter: update just after each rising edge
   initial begin
      in_stb   = '0;
      in_data  = '0;
      out1_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (!rst_n) q[i].delete();
            else if (in_ack[i] && q[i].size() > 0) void'(q[i].pop_front());
            in_stb[i]         = (q[i].size() > 0);
            in_data[8*i +: 8] = (q[i].size() > 0) ? q[i][0] : 8'h00;
         end
         case (ack_mode)
            0:       out1_ack = 1'b1;
            1:       out1_ack = ($urandom_range(0, 1) == 1);
            default: out1_ack = 1'b0;
         endcase
      end
   end

   // transfer log and acknowledge bookkeeping, sampled mid-cycle
   initial begin
      ack_viol = 0;
      for (int i = 0; i < N; i++) ack_cnt[i] = 0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (out1_stb && out1_ack) begin
               obs_g.push_back(grant);
               obs_b.push_back(out1);
            end
            if ((in_ack & ~grant) != 4'b0) ack_viol++;
            for (int i = 0; i < N; i++) if (in_ack[i]) ack_cnt[i]++;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic push_byte(input int i, input logic [7:0] b);
      q[i].push_back(b);
      mq[i].push_back(b);
   endtask

   task automatic push_str(input int i, input string s);
      for (int k = 0; k < s.len(); k++) push_byte(i, s[k]);
   endtask

   // Whole-line round-robin over the pending producer queues.
   task automatic model_compute();
      int         g;
      int         n;
      logic [7:0] b;
      exp_o.delete();
      exp_b.delete();
      forever begin
         g = -1;
         for (int k = 1; k <= N; k++)
            if (g < 0 && mq[(model_last + k) % N].size() > 0) g = (model_last + k) % N;
         if (g < 0) break;
`ifdef SERIAL_TX_ARBITER_TAG_EN
         exp_o.push_back(g);
         exp_b.push_back(8'(8'h30 + g));
`endif
         n = 0;
         do begin
            b = mq[g].pop_front();
            exp_o.push_back(g);
            exp_b.push_back(b);
            n++;
         end while (b != EOL && n < MAXL && mq[g].size() > 0);
         model_last = g;
      end
   endtask

   task automatic wait_done(input int base, input int budget, output bit done);
      done = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 && q[3].size() == 0 &&
             !busy && (obs_b.size() - base) >= exp_b.size()) begin
            done = 1'b1;
            break;
         end
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < N; i++) mq[i].delete();
      model_last = N - 1;
      ack_mode   = 0;
      rst_n      = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (in_ack !== 4'b0)   begin bad++; $display("FAIL reset_in_ack: got %b want 0000", in_ack); end
      total++; if (out1 !== 8'h00)    begin bad++; $display("FAIL reset_out1: got %h want 00", out1); end
      total++; if (out1_stb !== 1'b0) begin bad++; $display("FAIL reset_out1_stb: got %b want 0", out1_stb); end
      total++; if (grant !== 4'b0)    begin bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
      total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      apply_reset();
   endtask

   task automatic test_single();
      int base, ab, g_at, s_at;
      bit done;
      @(negedge clk);
      base = obs_b.size(); ab = ack_cnt[1]; g_at = -1; s_at = -1;
      push_str(1, "AB\n");
      model_compute();
      for (int n = 1; n <= 20 && s_at < 0; n++) begin
         @(negedge clk);
         if (grant != 4'b0 && g_at < 0) g_at = n;
         if (out1_stb && s_at < 0) s_at = n;
      end
      total++; if (g_at !== 2) begin bad++; $display("FAIL single_grant_latency: got %0d want 2", g_at); end
      total++; if (s_at !== FIRST_STB) begin bad++; $display("FAIL single_stb_latency: got %0d want %0d", s_at, FIRST_STB); end
      wait_done(base, 400, done);
      total++; if (!done) begin bad++; $display("FAIL single_done: got timeout want completion"); end
      total++; if (obs_b.size() - base !== exp_b.size()) begin bad++; $display("FAIL single_count: got %0d want %0d", obs_b.size() - base, exp_b.size()); end
      for (int j = 0; j < exp_b.size() && base + j < obs_b.size(); j++) begin
         total++;
         if (obs_b[base+j] !== exp_b[j] || obs_g[base+j] !== (4'b1 << exp_o[j])) begin
            bad++; $display("FAIL single_byte%0d: got %h/%b want %h/%b", j, obs_b[base+j], obs_g[base+j], exp_b[j], 4'b1 << exp_o[j]);
         end
      end
      total++; if (ack_cnt[1] - ab !== 3) begin bad++; $display("FAIL single_acks: got %0d want 3", ack_cnt[1] - ab); end
      total++; if (grant !== 4'b0) begin bad++; $display("FAIL single_release: got %b want 0000", grant); end
   endtask

   task automatic test_contention();
      int base, av;
      bit done;
      apply_reset();
      base = obs_b.size(); av = ack_viol;
      push_str(0, "x\n");
      push_str(2, "y\n");
      model_compute();
      wait_done(base, 400, done);
      total++; if (!done) begin bad++; $display("FAIL contention_done: got timeout want completion"); end
      total++; if (obs_b.size() - base !== exp_b.size()) begin bad++; $display("FAIL contention_count: got %0d want %0d", obs_b.size() - base, exp_b.size()); end
      for (int j = 0; j < exp_b.size() && base + j < obs_b.size(); j++) begin
         total++;
         if (obs_b[base+j] !== exp_b[j] || obs_g[base+j] !== (4'b1 << exp_o[j])) begin
            bad++; $display("FAIL contention_byte%0d: got %h/%b want %h/%b", j, obs_b[base+j], obs_g[base+j], exp_b[j], 4'b1 << exp_o[j]);
         end
      end
      total++; if (ack_viol - av !== 0) begin bad++; $display("FAIL contention_stray_ack: got %0d want 0", ack_viol - av); end
   endtask

   task automatic test_line_lock();
      int base;
      bit done;
      apply_reset();
      base = obs_b.size();
      push_str(0, "abc\nd\n");
      push_str(3, "Q\n");
      model_compute();
      wait_done(base, 600, done);
      total++; if (!done) begin bad++; $display("FAIL lock_done: got timeout want completion"); end
      total++; if (obs_b.size() - base !== exp_b.size()) begin bad++; $display("FAIL lock_count: got %0d want %0d", obs_b.size() - base, exp_b.size()); end
      for (int j = 0; j < exp_b.size() && base + j < obs_b.size(); j++) begin
         total++;
         if (obs_b[base+j] !== exp_b[j] || obs_g[base+j] !== (4'b1 << exp_o[j])) begin
            bad++; $display("FAIL lock_byte%0d: got %h/%b want %h/%b", j, obs_b[base+j], obs_g[base+j], exp_b[j], 4'b1 << exp_o[j]);
         end
      end
   endtask

   task automatic test_timeout();
      int  base, n_cap1, n_gap;
      bit  seen1, seen2, done;
      @(negedge clk);
      base = obs_b.size(); n_cap1 = 0; n_gap = 0; seen1 = 0; seen2 = 0;
      push_str(1, "a");
      push_str(2, "k\n");
      model_compute();
      for (int n = 0; n < 200 && !seen2; n++) begin
         @(negedge clk);
         if (grant == 4'b0010) seen1 = 1'b1;
         if (grant == 4'b0100) seen2 = 1'b1;
         if (grant == 4'b0010 && !out1_stb) n_cap1++;
         if (grant == 4'b0 && seen1 && !seen2) n_gap++;
      end
      total++; if (n_cap1 !== TMO) begin bad++; $display("FAIL timeout_hold: got %0d want %0d", n_cap1, TMO); end
      total++; if (n_gap !== 1) begin bad++; $display("FAIL timeout_gap: got %0d want 1", n_gap); end
      wait_done(base, 400, done);
      total++; if (!done) begin bad++; $display("FAIL timeout_done: got timeout want completion"); end
      total++; if (obs_b.size() - base !== exp_b.size()) begin bad++; $display("FAIL timeout_count: got %0d want %0d", obs_b.size() - base, exp_b.size()); end
      for (int j = 0; j < exp_b.size() && base + j < obs_b.size(); j++) begin
         total++;
         if (obs_b[base+j] !== exp_b[j] || obs_g[base+j] !== (4'b1 << exp_o[j])) begin
            bad++; $display("FAIL timeout_byte%0d: got %h/%b want %h/%b", j, obs_b[base+j], obs_g[base+j], exp_b[j], 4'b1 << exp_o[j]);
         end
      end
   endtask

   task automatic test_max_line();
      int base, a0;
      bit done;
      @(negedge clk);
      base = obs_b.size(); a0 = ack_cnt[0];
      push_str(0, "ABCDEF");
      push_str(1, "r\n");
      model_compute();
      wait_done(base, 600, done);
      total++; if (!done) begin bad++; $display("FAIL maxline_done: got timeout want completion"); end
      total++; if (obs_b.size() - base !== exp_b.size()) begin bad++; $display("FAIL maxline_count: got %0d want %0d", obs_b.size() - base, exp_b.size()); end
      for (int j = 0; j < exp_b.size() && base + j < obs_b.size(); j++) begin
         total++;
         if (obs_b[base+j] !== exp_b[j] || obs_g[base+j] !== (4'b1 << exp_o[j])) begin
            bad++; $display("FAIL maxline_byte%0d: got %h/%b want %h/%b", j, obs_b[base+j], obs_g[base+j], exp_b[j], 4'b1 << exp_o[j]);
         end
      end
      total++; if (ack_cnt[0] - a0 !== 6) begin bad++; $display("FAIL maxline_acks: got %0d want 6", ack_cnt[0] - a0); end
   endtask

   task automatic test_backpressure();
      logic [7:0] v;
      logic [3:0] g;
      bit         stable, seen;
      ack_mode = 2;
      @(negedge clk);
      push_str(2, "Z\n");
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (out1_stb) seen = 1'b1;
      end
      total++; if (!seen) begin bad++; $display("FAIL bp_stb_seen: got no out1_stb want strobe"); end
      v = out1; g = grant; stable = 1'b1;
      total++; if (v !== BP_BYTE) begin bad++; $display("FAIL bp_byte: got %h want %h", v, BP_BYTE); end
      repeat (20) begin
         @(negedge clk);
         if (out1 !== v || out1_stb !== 1'b1 || grant !== g) stable = 1'b0;
      end
      total++; if (!stable || g !== 4'b0100) begin bad++; $display("FAIL bp_stable: got stable=%b grant=%b want stable=1 grant=0100", stable, g); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (out1_stb !== 1'b0) begin bad++; $display("FAIL bp_rst_stb: got %b want 0", out1_stb); end
      total++; if (grant !== 4'b0)    begin bad++; $display("FAIL bp_rst_grant: got %b want 0000", grant); end
      total++; if (in_ack !== 4'b0)   begin bad++; $display("FAIL bp_rst_ack: got %b want 0000", in_ack); end
      total++; if (busy !== 1'b0)     begin bad++; $display("FAIL bp_rst_busy: got %b want 0", busy); end
      apply_reset();
   endtask

   task automatic test_random();
      int  base, nl, len;
      int  ab[4], np[4];
      bit  done;
      ack_mode = 1;
      for (int r = 0; r < 6; r++) begin
         @(negedge clk);
         base = obs_b.size();
         for (int i = 0; i < N; i++) begin
            ab[i] = ack_cnt[i]; np[i] = 0;
            nl = $urandom_range(0, 2);
            for (int l = 0; l < nl; l++) begin
               len = $urandom_range(1, 6);
               for (int k = 0; k < len; k++) begin
                  push_byte(i, 8'($urandom_range(32, 126)));
                  np[i]++;
               end
               if ($urandom_range(0, 3) != 0) begin
                  push_byte(i, EOL);
                  np[i]++;
               end
            end
         end
         model_compute();
         wait_done(base, 3000, done);
         total++; if (!done) begin bad++; $display("FAIL rand%0d_done: got timeout want completion", r); end
         total++; if (obs_b.size() - base !== exp_b.size()) begin bad++; $display("FAIL rand%0d_count: got %0d want %0d", r, obs_b.size() - base, exp_b.size()); end
         for (int j = 0; j < exp_b.size() && base + j < obs_b.size(); j++) begin
            total++;
            if (obs_b[base+j] !== exp_b[j] || obs_g[base+j] !== (4'b1 << exp_o[j])) begin
               bad++; $display("FAIL rand%0d_byte%0d: got %h/%b want %h/%b", r, j, obs_b[base+j], obs_g[base+j], exp_b[j], 4'b1 << exp_o[j]);
            end
         end
         for (int i = 0; i < N; i++) begin
            total++;
            if (ack_cnt[i] - ab[i] !== np[i]) begin bad++; $display("FAIL rand%0d_acks%0d: got %0d want %0d", r, i, ack_cnt[i] - ab[i], np[i]); end
         end
      end
      ack_mode = 0;
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      rst_n      = 1'b0;
      ack_mode   = 0;
      model_last = N - 1;
      test_reset();
      test_single();
      test_contention();
      test_line_lock();
      test_timeout();
      test_max_line();
      test_backpressure();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
- Round-robin arbiter that shares one byte-wide serial transmitter (stb/ack byte sink, e.g. the 115200-baud serial_output) between N_INPUTS byte producers: SoC stdout, boot monitor, debug/status sources.
- Grant is line-locked: a granted producer keeps the transmitter until it sends the end-of-line byte, hits the line-length limit, or goes idle past a timeout. Text lines from different sources therefore never interleave mid-line.
- Sits between the producers and the serial transmitter in the clk_50 domain.

Parameters:
- N_INPUTS, 4, number of requesters (2..8).
- EOL_CHAR, 8'h0A, byte that ends a line and releases the grant.
- MAX_LINE, 256, maximum bytes per grant before a forced release (1..65535).
- TIMEOUT, 50000, consecutive idle cycles of the granted producer before release (1 ms at 50 MHz; ≥2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  8*N_INPUTS  producer bytes; byte i at [8*i+7:8*i].
- in_stb  input  N_INPUTS  producer i has a valid byte; held with data until acked.
- in_ack  output  N_INPUTS  one-cycle registered pulse: byte i taken.
- out1  output  8  byte to transmitter.
- out1_stb  output  1  out1 valid.
- out1_ack  input  1  transmitter accepts; a transfer completes on any edge with out1_stb & out1_ack.
- grant  output  N_INPUTS  one-hot current owner; 0 when idle.
- busy  output  1  high whenever state ≠ IDLE.

Behaviour:
- Reset is asynchronous on rst_n low. All of the following are 0: in_ack, out1, out1_stb, grant, busy, byte/idle counters. State goes to IDLE. The last-grant pointer is set to N_INPUTS-1, so input 0 has first priority.
- States: IDLE, CAPTURE, SEND; the optional feature adds TAG.
- IDLE:
  - If any in_stb is high, select the first set bit searching from last+1, wrapping modulo N_INPUTS.
  - Register grant, zero the byte and idle counters, go to CAPTURE.
  - If no in_stb is high, remain in IDLE.
- CAPTURE:
  - If in_stb[g] is high: latch in_data[g] into out1, set out1_stb, pulse in_ack[g] for exactly one cycle, increment the byte counter, clear the idle counter, go to SEND.
  - Otherwise increment the idle counter. At TIMEOUT-1, release: grant becomes 0, last becomes g, go to IDLE.
  - Ungranted inputs never see in_ack.
- SEND:
  - Hold out1/out1_stb stable until out1_ack.
  - On the ack edge, out1_stb falls. If out1 == EOL_CHAR or byte count == MAX_LINE, release to IDLE (last = g). Otherwise go to CAPTURE.
- Latency: in_stb seen at edge k in IDLE → grant at k+1 → out1_stb and in_ack[g] high from edge k+2.
- Within a held grant: each SEND→CAPTURE→SEND turnaround costs one cycle after out1_ack.
- Timing assumption: the producer drops or updates in_stb/data at the edge where it sees in_ack. CAPTURE is re-entered only after at least one SEND cycle, so the same byte is never captured twice.
- Round-robin fairness: after a release, the just-served input has the lowest priority. With all inputs requesting, grants rotate 0,1,2,3,0,…
- An in_stb falling mid-line without EOL holds the grant until TIMEOUT expires; other requesters wait.
- out1_ack while out1_stb is low is ignored.
- Reset mid-SEND drops out1_stb immediately. The partially sent byte is not retried.
- Counters are sized with $clog2(MAX_LINE+1) and $clog2(TIMEOUT). There is no wrap-around, because release occurs at the limit.

Optional Feature:
- Macro: SERIAL_TX_ARBITER_TAG_EN.
- When defined, each grant begins in TAG:
  - out1 = 8'h30 + g (ASCII digit) with out1_stb, sent before the first producer byte; no in_ack is pulsed.
  - On out1_ack, go to CAPTURE.
  - The tag does not count toward MAX_LINE.
  - First-byte latency becomes tag completion + 1 cycle.
- When undefined, the TAG state and its logic are absent and output is byte-transparent.

Test Plan:
- Single producer: input 1 sends "AB\n" with out1_ack tied high → out1 = 41, 42, 0A; three in_ack[1] pulses; grant = 0010 until after 0A, then 0; first out1_stb two cycles after in_stb.
- Contention: inputs 0 and 2 request simultaneously from reset; 0 sends "x\n" and 2 sends "y\n" → out1 sequence 78, 0A, 79, 0A; in_ack[2] is never pulsed while grant = 0001.
- Line lock with rotation: input 0 sends "abc\n" while input 3 requests the whole time → no byte from input 3 appears before 0A; next grant = 1000; the following grant to input 0 comes only after 3 is served.
- Timeout: input 1 sends "a" then drops in_stb with TIMEOUT=10 → grant holds 9 idle cycles in CAPTURE then returns to 0; pending input 2 is granted next cycle.
- MAX_LINE=4: input 0 streams 6 non-EOL bytes → release after the 4th ack; input 0 is re-granted only after other requesters are served; bytes 5–6 follow intact.
- Backpressure and reset: out1_ack held low 20 cycles → out1 and out1_stb stable throughout; rst_n pulsed low mid-SEND → out1_stb, grant and in_ack go to 0 asynchronously, state is IDLE. With the tag macro defined, the single-producer test yields 31, 41, 42, 0A.
